// File: rtl/control_vec_pkg.sv
// Shared encodings and control bundles for the vector pipeline controller.
// The ALU field is carried at its 3-bit base width and widened at the top level.
package control_vec_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_VR   = 6'b010000;
  localparam logic [5:0] OP_VLW  = 6'b110011;
  localparam logic [5:0] OP_VSW  = 6'b111011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_t;

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       vregwrite;
    logic       vector;
    logic [2:0] alucontrol;
  } ctrl_e_t;

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic regwrite;
    logic vregwrite;
  } ctrl_m_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic vregwrite;
  } ctrl_w_t;

  // Unknown funct values fall back to add so R-type NOP-like encodings stay harmless.
  function automatic logic [2:0] funct_alu(input logic [5:0] funct);
    logic [2:0] code;
    case (funct)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_SLT:  code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_vec_decode.sv
// Combinational D-stage decoder: opcode/funct to the E control bundle plus
// the D-only branch, jump and vector memory source signals.
module vec_decode
  import control_vec_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_e_t    ctrl,
  output logic [1:0] branch,
  output logic       jump,
  output logic       memsrc
);

  always_comb begin
    ctrl   = '0;
    branch = BR_NONE;
    jump   = 1'b0;
    memsrc = 1'b0;
    case (op)
      OP_R: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.alucontrol = funct_alu(funct);
      end
      OP_LW: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        branch          = BR_EQ;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_BNE: begin
        branch          = BR_NE;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_J: begin
        jump = 1'b1;
      end
      OP_VR: begin
        ctrl.vregwrite  = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.vector     = 1'b1;
        ctrl.alucontrol = funct_alu(funct);
      end
      OP_VLW: begin
        ctrl.vregwrite = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.memtoreg  = 1'b1;
        ctrl.vector    = 1'b1;
        memsrc         = 1'b1;
      end
      OP_VSW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.vector   = 1'b1;
        memsrc        = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/control_vec.sv
// Pipeline controller with multi-beat vector ops: decodes in D, resolves
// branches in D, and sequences E/M/W control with a beat counter that stalls D.
module control_vec
  import control_vec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ALU_W  = 3,
  parameter int VLEN   = 8,
  parameter int LANES  = 4,
  parameter int BEAT_W = ((VLEN / LANES) > 1) ? $clog2(VLEN / LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opD,
  input  logic [5:0]        functD,
  input  logic [DATA_W-1:0] srca2D,
  input  logic [DATA_W-1:0] srcb2D,
  input  logic              flushE,
  input  logic              stallE,
  output logic              pcsrcD,
  output logic [1:0]        branchD,
  output logic              jumpD,
  output logic              memsrcD,
  output logic              stallD,
  output logic              memtoregE,
  output logic              alusrcE,
  output logic              regdstE,
  output logic              regwriteE,
  output logic              vregwriteE,
  output logic [ALU_W-1:0]  alucontrolE,
  output logic [BEAT_W-1:0] vbeatE,
  output logic              busyE,
  output logic              memtoregM,
  output logic              memwriteM,
  output logic              regwriteM,
  output logic              vregwriteM,
  output logic [BEAT_W-1:0] vbeatM,
  output logic              memtoregW,
  output logic              regwriteW,
  output logic              vregwriteW,
  output logic [BEAT_W-1:0] vbeatW
);

  localparam int BEATS = VLEN / LANES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (LANES < 1 || VLEN < LANES || (VLEN % LANES) != 0) begin : g_bad_lanes
    $error("control_vec: VLEN must be a positive multiple of LANES");
  end
  if (ALU_W < 3) begin : g_bad_alu_w
    $error("control_vec: ALU_W must hold the 3-bit ALU codes");
  end

  ctrl_e_t           dec_ctrl;
  logic [1:0]        dec_branch;
  logic              dec_jump;
  logic              dec_memsrc;

  ctrl_e_t           e_d, e_q;
  logic [BEAT_W-1:0] beat_d, beat_q;
  ctrl_m_t           m_d, m_q;
  logic [BEAT_W-1:0] vbeat_m_d, vbeat_m_q;
  ctrl_w_t           w_d, w_q;
  logic [BEAT_W-1:0] vbeat_w_d, vbeat_w_q;
  logic              in_seq;

  vec_decode u_decode (
    .op     (opD),
    .funct  (functD),
    .ctrl   (dec_ctrl),
    .branch (dec_branch),
    .jump   (dec_jump),
    .memsrc (dec_memsrc)
  );

  assign branchD = dec_branch;
  assign jumpD   = dec_jump;
  assign memsrcD = dec_memsrc;
  assign pcsrcD  = ((dec_branch == BR_EQ) && (srca2D == srcb2D)) ||
                   ((dec_branch == BR_NE) && (srca2D != srcb2D));

  // A vector op keeps E until its final beat has been issued.
  assign in_seq = e_q.vector && (beat_q != LAST_BEAT);
  assign busyE  = in_seq && !flushE;
  assign stallD = busyE || stallE;

  always_comb begin
    e_d    = e_q;
    beat_d = beat_q;
    if (flushE) begin
      e_d    = '0;
      beat_d = '0;
    end else if (stallE) begin
      e_d    = e_q;
      beat_d = beat_q;
    end else if (in_seq) begin
      beat_d = beat_q + BEAT_W'(1);
    end else begin
      e_d    = dec_ctrl;
      beat_d = '0;
    end
  end

  // Every non-stalled cycle hands one beat (or one scalar op) to M.
  always_comb begin
    m_d.memtoreg  = e_q.memtoreg;
    m_d.memwrite  = e_q.memwrite;
    m_d.regwrite  = e_q.regwrite;
    m_d.vregwrite = e_q.vregwrite;
    vbeat_m_d     = beat_q;
    if (stallE) begin
      m_d       = '0;
      vbeat_m_d = '0;
    end
    w_d.memtoreg  = m_q.memtoreg;
    w_d.regwrite  = m_q.regwrite;
    w_d.vregwrite = m_q.vregwrite;
    vbeat_w_d     = vbeat_m_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      beat_q    <= '0;
      m_q       <= '0;
      vbeat_m_q <= '0;
      w_q       <= '0;
      vbeat_w_q <= '0;
    end else begin
      e_q       <= e_d;
      beat_q    <= beat_d;
      m_q       <= m_d;
      vbeat_m_q <= vbeat_m_d;
      w_q       <= w_d;
      vbeat_w_q <= vbeat_w_d;
    end
  end

  assign memtoregE   = e_q.memtoreg;
  assign alusrcE     = e_q.alusrc;
  assign regdstE     = e_q.regdst;
  assign regwriteE   = e_q.regwrite;
  assign vregwriteE  = e_q.vregwrite;
  assign alucontrolE = ALU_W'(e_q.alucontrol);
  assign vbeatE      = beat_q;

  assign memtoregM  = m_q.memtoreg;
  assign memwriteM  = m_q.memwrite;
  assign regwriteM  = m_q.regwrite;
  assign vregwriteM = m_q.vregwrite;
  assign vbeatM     = vbeat_m_q;

  assign memtoregW  = w_q.memtoreg;
  assign regwriteW  = w_q.regwrite;
  assign vregwriteW = w_q.vregwrite;
  assign vbeatW     = vbeat_w_q;

endmodule

// File: tb/tb_control_vec.sv
// Bench for control_vec: decode table with an M/W scoreboard on a 2-beat instance,
// hand sequences for stall/flush/reset on a 4-beat instance, and a 1-beat instance.
module tb_control_vec;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_J = 6'b000010, T_VR = 6'b010000, T_VLW = 6'b110011;
  localparam logic [5:0] T_VSW = 6'b111011, T_NOP = 6'b111111;

  logic clk = 1'b0;
  logic reset, flushE, stallE;
  logic [5:0] opD, functD;
  logic [31:0] srca2D, srcb2D;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance a: VLEN 8 / LANES 4 -> 2 beats
  logic pcsrcD_a, jumpD_a, memsrcD_a, stallD_a, memtoregE_a, alusrcE_a, regdstE_a;
  logic regwriteE_a, vregwriteE_a, busyE_a, memtoregM_a, memwriteM_a, regwriteM_a;
  logic vregwriteM_a, memtoregW_a, regwriteW_a, vregwriteW_a;
  logic [1:0] branchD_a;
  logic [2:0] alucontrolE_a;
  logic [0:0] vbeatE_a, vbeatM_a, vbeatW_a;

  control_vec #(.DATA_W(32), .ALU_W(3), .VLEN(8), .LANES(4)) dut_a (
    .clk(clk), .reset(reset), .opD(opD), .functD(functD), .srca2D(srca2D), .srcb2D(srcb2D),
    .flushE(flushE), .stallE(stallE), .pcsrcD(pcsrcD_a), .branchD(branchD_a), .jumpD(jumpD_a),
    .memsrcD(memsrcD_a), .stallD(stallD_a), .memtoregE(memtoregE_a), .alusrcE(alusrcE_a),
    .regdstE(regdstE_a), .regwriteE(regwriteE_a), .vregwriteE(vregwriteE_a),
    .alucontrolE(alucontrolE_a), .vbeatE(vbeatE_a), .busyE(busyE_a), .memtoregM(memtoregM_a),
    .memwriteM(memwriteM_a), .regwriteM(regwriteM_a), .vregwriteM(vregwriteM_a),
    .vbeatM(vbeatM_a), .memtoregW(memtoregW_a), .regwriteW(regwriteW_a),
    .vregwriteW(vregwriteW_a), .vbeatW(vbeatW_a));

  // Instance b: VLEN 16 / LANES 4 -> 4 beats
  logic pcsrcD_b, jumpD_b, memsrcD_b, stallD_b, memtoregE_b, alusrcE_b, regdstE_b;
  logic regwriteE_b, vregwriteE_b, busyE_b, memtoregM_b, memwriteM_b, regwriteM_b;
  logic vregwriteM_b, memtoregW_b, regwriteW_b, vregwriteW_b;
  logic [1:0] branchD_b;
  logic [2:0] alucontrolE_b;
  logic [1:0] vbeatE_b, vbeatM_b, vbeatW_b;

  control_vec #(.DATA_W(32), .ALU_W(3), .VLEN(16), .LANES(4)) dut_b (
    .clk(clk), .reset(reset), .opD(opD), .functD(functD), .srca2D(srca2D), .srcb2D(srcb2D),
    .flushE(flushE), .stallE(stallE), .pcsrcD(pcsrcD_b), .branchD(branchD_b), .jumpD(jumpD_b),
    .memsrcD(memsrcD_b), .stallD(stallD_b), .memtoregE(memtoregE_b), .alusrcE(alusrcE_b),
    .regdstE(regdstE_b), .regwriteE(regwriteE_b), .vregwriteE(vregwriteE_b),
    .alucontrolE(alucontrolE_b), .vbeatE(vbeatE_b), .busyE(busyE_b), .memtoregM(memtoregM_b),
    .memwriteM(memwriteM_b), .regwriteM(regwriteM_b), .vregwriteM(vregwriteM_b),
    .vbeatM(vbeatM_b), .memtoregW(memtoregW_b), .regwriteW(regwriteW_b),
    .vregwriteW(vregwriteW_b), .vbeatW(vbeatW_b));

  // Instance c: VLEN 4 / LANES 4 -> 1 beat
  logic pcsrcD_c, jumpD_c, memsrcD_c, stallD_c, memtoregE_c, alusrcE_c, regdstE_c;
  logic regwriteE_c, vregwriteE_c, busyE_c, memtoregM_c, memwriteM_c, regwriteM_c;
  logic vregwriteM_c, memtoregW_c, regwriteW_c, vregwriteW_c;
  logic [1:0] branchD_c;
  logic [2:0] alucontrolE_c;
  logic [0:0] vbeatE_c, vbeatM_c, vbeatW_c;

  control_vec #(.DATA_W(32), .ALU_W(3), .VLEN(4), .LANES(4)) dut_c (
    .clk(clk), .reset(reset), .opD(opD), .functD(functD), .srca2D(srca2D), .srcb2D(srcb2D),
    .flushE(flushE), .stallE(stallE), .pcsrcD(pcsrcD_c), .branchD(branchD_c), .jumpD(jumpD_c),
    .memsrcD(memsrcD_c), .stallD(stallD_c), .memtoregE(memtoregE_c), .alusrcE(alusrcE_c),
    .regdstE(regdstE_c), .regwriteE(regwriteE_c), .vregwriteE(vregwriteE_c),
    .alucontrolE(alucontrolE_c), .vbeatE(vbeatE_c), .busyE(busyE_c), .memtoregM(memtoregM_c),
    .memwriteM(memwriteM_c), .regwriteM(regwriteM_c), .vregwriteM(vregwriteM_c),
    .vbeatM(vbeatM_c), .memtoregW(memtoregW_c), .regwriteW(regwriteW_c),
    .vregwriteW(vregwriteW_c), .vbeatW(vbeatW_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard of expected M entries for instance a; W must replay M one cycle later.
  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic       vregwrite;
    logic [0:0] vbeat;
  } m_exp_t;

  m_exp_t sb_q[$];
  m_exp_t m_act, m_exp_v, w_act;
  m_exp_t w_exp = '0;
  logic   mon_en = 1'b0;
  logic   c_mon = 1'b0;
  logic   c_busy_seen = 1'b0;
  logic   c_beat_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      w_act = '{memtoregW_a, 1'b0, regwriteW_a, vregwriteW_a, vbeatW_a};
      chk("w_follows_m", w_act, w_exp);
      m_act = '{memtoregM_a, memwriteM_a, regwriteM_a, vregwriteM_a, vbeatM_a};
      w_exp = '0;
      if (m_act.memtoreg || m_act.memwrite || m_act.regwrite || m_act.vregwrite) begin
        if (sb_q.size() == 0) begin
          chk("m_unexpected_entry", m_act, 32'h0);
        end else begin
          m_exp_v = sb_q.pop_front();
          chk("m_entry", m_act, m_exp_v);
          w_exp = m_exp_v;
          w_exp.memwrite = 1'b0;
        end
      end
    end else begin
      w_exp = '0;
    end
    if (c_mon) begin
      if (busyE_c) c_busy_seen = 1'b1;
      if (vbeatE_c != 1'b0 || vbeatM_c != 1'b0) c_beat_seen = 1'b1;
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        pcsrc;
    logic [1:0]  branch;
    logic        jump;
    logic        memsrc;
    logic [2:0]  alu;
    logic        regdst;
    logic        alusrc;
    logic        mtr_e;
    logic [3:0]  m_bits;  // memtoreg, memwrite, regwrite, vregwrite
    int          beats;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];

  // 4-beat VLW with stallE on beat 1: per-cycle stimulus and expected E/M state
  int seq_stall[6] = '{0, 1, 0, 0, 0, 0};
  int seq_vbe[6]   = '{1, 1, 2, 3, 0, 0};
  int seq_busy[6]  = '{1, 1, 1, 0, 0, 0};
  int seq_mv[6]    = '{1, 0, 1, 1, 1, 0};
  int seq_mb[6]    = '{0, 0, 1, 2, 3, 0};

  task automatic wait_free_a();
    int n = 0;
    while (stallD_a && n < 50) begin
      step();
      n++;
    end
    chk("issue_stall_bound", {31'd0, stallD_a}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{T_R,    6'b100000, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 4'b0010, 1};
    vt[1]  = '{T_LW,   6'b100010, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 4'b1010, 1};
    vt[2]  = '{T_SW,   6'b000000, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0100, 1};
    vt[3]  = '{T_BEQ,  6'b000000, 32'd5, 32'd5, 1'b1, 2'b01, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[4]  = '{T_BEQ,  6'b000000, 32'd5, 32'd6, 1'b0, 2'b01, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[5]  = '{T_BNE,  6'b000000, 32'd5, 32'd5, 1'b0, 2'b10, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[6]  = '{T_BNE,  6'b000000, 32'd5, 32'd6, 1'b1, 2'b10, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[7]  = '{T_ADDI, 6'b000000, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0010, 1};
    vt[8]  = '{T_J,    6'b000000, 32'd7, 32'd7, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[9]  = '{T_R,    6'b100010, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 4'b0010, 1};
    vt[10] = '{T_R,    6'b100100, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0010, 1};
    vt[11] = '{T_R,    6'b100101, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0010, 1};
    vt[12] = '{T_R,    6'b101010, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 4'b0010, 1};
    vt[13] = '{T_R,    6'b000111, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 4'b0010, 1};
    vt[14] = '{T_VR,   6'b100101, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 4'b0001, 2};
    vt[15] = '{T_VLW,  6'b000000, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 4'b1001, 2};
    vt[16] = '{T_VSW,  6'b000000, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0100, 2};
    vt[17] = '{T_NOP,  6'b100000, 32'd3, 32'd3, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[18] = '{T_BEQ,  6'b000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b01, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[19] = '{T_BNE,  6'b000000, 32'h8000_0000, 32'h0, 1'b1, 2'b10, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0000, 1};

    // Reset for two edges with a live opcode on D
    reset = 1'b1; flushE = 1'b0; stallE = 1'b0;
    opD = T_LW; functD = 6'b100000; srca2D = '0; srcb2D = '0;
    step();
    opD = T_VR;
    step();
    chk("reset_a_regs", {memtoregE_a, alusrcE_a, regdstE_a, regwriteE_a, vregwriteE_a,
        alucontrolE_a, vbeatE_a, busyE_a, memtoregM_a, memwriteM_a, regwriteM_a,
        vregwriteM_a, vbeatM_a, memtoregW_a, regwriteW_a, vregwriteW_a, vbeatW_a}, 32'd0);
    chk("reset_b_regs", {vregwriteE_b, vbeatE_b, busyE_b, vregwriteM_b, vbeatM_b,
        vregwriteW_b, vbeatW_b}, 32'd0);
    reset = 1'b0; opD = T_NOP;
    mon_en = 1'b1; c_mon = 1'b1;

    for (int i = 0; i < NV; i++) begin
      opD = vt[i].op; functD = vt[i].funct; srca2D = vt[i].a; srcb2D = vt[i].b;
      #1;
      $display("vec %0d: op=%b funct=%b a=%0h b=%0h", i, vt[i].op, vt[i].funct, vt[i].a, vt[i].b);
      chk("pcsrcD", {31'd0, pcsrcD_a}, {31'd0, vt[i].pcsrc});
      chk("branchD", {30'd0, branchD_a}, {30'd0, vt[i].branch});
      chk("jumpD", {31'd0, jumpD_a}, {31'd0, vt[i].jump});
      chk("memsrcD", {31'd0, memsrcD_a}, {31'd0, vt[i].memsrc});
      wait_free_a();
      if (vt[i].m_bits != 4'b0000) begin
        for (int k = 0; k < vt[i].beats; k++)
          sb_q.push_back(m_exp_t'{vt[i].m_bits[3], vt[i].m_bits[2], vt[i].m_bits[1],
                                  vt[i].m_bits[0], k[0:0]});
      end
      step();
      chk("alucontrolE", {29'd0, alucontrolE_a}, {29'd0, vt[i].alu});
      chk("regdstE", {31'd0, regdstE_a}, {31'd0, vt[i].regdst});
      chk("alusrcE", {31'd0, alusrcE_a}, {31'd0, vt[i].alusrc});
      chk("memtoregE", {31'd0, memtoregE_a}, {31'd0, vt[i].mtr_e});
      chk("regwriteE", {31'd0, regwriteE_a}, {31'd0, vt[i].m_bits[1]});
      chk("vregwriteE", {31'd0, vregwriteE_a}, {31'd0, vt[i].m_bits[0]});
      chk("vbeatE_first", {31'd0, vbeatE_a}, 32'd0);
      chk("busyE_first", {31'd0, busyE_a}, (vt[i].beats > 1) ? 32'd1 : 32'd0);
    end
    opD = T_NOP;
    wait_free_a();
    repeat (4) step();
    chk("sb_drain_table", sb_q.size(), 32'd0);

    // 2-beat VR followed by ADD: one stall cycle, ADD enters E on cycle 3
    $display("seq: 2-beat VR then ADD");
    opD = T_VR; functD = 6'b100000;
    sb_q.push_back(m_exp_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    sb_q.push_back(m_exp_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    sb_q.push_back(m_exp_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    step();
    opD = T_R; functD = 6'b100000;
    #1;
    chk("vr_c1_busy_stall_beat", {busyE_a, stallD_a, vbeatE_a}, 32'b110);
    step();
    chk("vr_c2_busy_stall_beat", {busyE_a, stallD_a, vbeatE_a}, 32'b001);
    chk("vr_c2_m", {vregwriteM_a, vbeatM_a}, 32'b10);
    step();
    opD = T_NOP;
    chk("vr_c3_e_add", {regdstE_a, regwriteE_a, vregwriteE_a, vbeatE_a}, 32'b1100);
    chk("vr_c3_m", {vregwriteM_a, vbeatM_a}, 32'b11);
    step();
    chk("vr_c4_m_add", {regwriteM_a, vregwriteM_a}, 32'b10);
    repeat (3) step();
    chk("sb_drain_vr", sb_q.size(), 32'd0);
    mon_en = 1'b0;

    // 4-beat VLW with stallE on beat 1
    $display("seq: 4-beat VLW with stallE on beat 1");
    opD = T_VLW;
    step();
    opD = T_NOP;
    chk("vlw_c0_beat_busy", {vbeatE_b, busyE_b}, 32'b001);
    for (int c = 0; c < 6; c++) begin
      stallE = (seq_stall[c] != 0);
      #1;
      if (stallE) chk("vlw_stall_stallD", {31'd0, stallD_b}, 32'd1);
      step();
      stallE = 1'b0;
      chk("vlw_vbeatE", {30'd0, vbeatE_b}, seq_vbe[c]);
      chk("vlw_busyE", {31'd0, busyE_b}, seq_busy[c]);
      chk("vlw_m_valid", {30'd0, vregwriteM_b, memtoregM_b}, seq_mv[c] * 3);
      chk("vlw_vbeatM", {30'd0, vbeatM_b}, seq_mb[c]);
    end

    // 4-beat VR flushed once beat 1 is in E: only beats 0 and 1 reach M
    $display("seq: 4-beat VR with flushE");
    opD = T_VR; functD = 6'b100101;
    step();
    opD = T_NOP;
    step();
    chk("flush_pre_beat", {vbeatE_b, busyE_b, vregwriteM_b, vbeatM_b}, 32'b011100);
    flushE = 1'b1;
    #1;
    chk("flush_same_cycle", {busyE_b, stallD_b}, 32'b00);
    step();
    flushE = 1'b0;
    chk("flush_e_cleared", {vbeatE_b, vregwriteE_b, busyE_b}, 32'd0);
    chk("flush_m_beat1", {vregwriteM_b, vbeatM_b}, 32'b101);
    step();
    chk("flush_no_beat2", {vregwriteM_b, vbeatM_b}, 32'd0);
    step();
    chk("flush_no_beat3", {vregwriteM_b, vbeatM_b}, 32'd0);

    // flushE and stallE together on beat 0: flush clears E, stall bubbles M
    $display("seq: flushE with stallE");
    opD = T_VR;
    step();
    opD = T_NOP;
    flushE = 1'b1; stallE = 1'b1;
    step();
    flushE = 1'b0; stallE = 1'b0;
    chk("flush_stall_e", {vbeatE_b, vregwriteE_b, busyE_b}, 32'd0);
    chk("flush_stall_m", {vregwriteM_b, vbeatM_b}, 32'd0);
    step();
    chk("flush_stall_after", {vregwriteM_b, vregwriteW_b}, 32'd0);

    // Reset in the middle of a 4-beat sequence
    $display("seq: reset mid-sequence");
    opD = T_VR;
    step();
    opD = T_NOP;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid", {vbeatE_b, busyE_b, vregwriteE_b, vregwriteM_b, vbeatM_b,
        vregwriteW_b, vbeatW_b}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset_mid_no_beats", {vregwriteM_b, vbeatM_b, vbeatE_b, busyE_b}, 32'd0);
    end

    chk("beats1_busy_never", {31'd0, c_busy_seen}, 32'd0);
    chk("beats1_vbeat_zero", {31'd0, c_beat_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
